acc_cmd_arbiter: RTL and testbench
==================================

ACC_CMD_ARBITER -- requirements
Module: acc_cmd_arbiter

Interface
REQ-001 SHALL have parameter none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; low = synchronous flush.
REQ-005 prio_fixed  input  1  1 = requester 0 always wins; 0 = round-robin.
REQ-006 req0_valid / req1_valid  input  1 each  requester holds command pending.
REQ-007 req0_op / req1_op  input  2 each  0=LOAD, 1=ADD, 2=SUB, 3=STORE.
REQ-008 req0_data / req1_data  input  8 each  LOAD operand; ignored for other ops.
REQ-009 req0_ready / req1_ready  output  1 each  one-cycle acceptance pulse.
REQ-010 cmd_out  output  8  command byte to accumulator core input bus.
REQ-011 acc_in  input  8  accumulator value from core.
REQ-012 rsp_valid  output  1  one-cycle result pulse.
REQ-013 rsp_id  output  1  requester owning the result.
REQ-014 rsp_data  output  8  accumulator value sampled for the result.
REQ-015 busy  output  1  high whenever state is not ARB.

Function
REQ-016 SHALL implement states ARB, OPC, OPND, RESP; ARB -> OPC only on a grant; OPC -> OPND -> RESP -> ARB unconditionally.
REQ-017 In ARB with any valid: grant per REQ-018/019, pulse that requester's ready same cycle, register op, data, id.
REQ-018 Round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last_grant updates on every grant.
REQ-019 prio_fixed=1: both valid -> grant requester 0; last_grant still updates.
REQ-020 Requester SHALL hold valid/op/data stable until ready; at most one ready per cycle, never in a non-ARB state.
REQ-021 cmd_out in OPC = op+1 (0x01 LOAD, 0x02 ADD, 0x03 SUB, 0x04 STORE).
REQ-022 cmd_out in OPND = registered data for LOAD, 0x00 otherwise.
REQ-023 cmd_out = 0x00 in ARB and RESP; cmd_out registered (driven from state/regs, no combinational path from req inputs).
REQ-024 In RESP: rsp_valid=1 one cycle, rsp_id=registered id, rsp_data=acc_in sampled that cycle; rsp_id/rsp_data hold until next RESP.
REQ-025 Command throughput: one command per 4 cycles (ARB grant, OPC, OPND, RESP); grant latency 0 cycles from valid in ARB.
REQ-026 Valid deasserting in OPC/OPND/RESP SHALL not affect the in-flight command.
REQ-027 ena=0 at a clock edge: state -> ARB, cmd_out -> 0x00, rsp_valid 0, in-flight command dropped without response, last_grant unchanged, no ready.
REQ-028 Arithmetic is performed only by the core; block does no wrap handling, rsp_data passes acc_in unmodified (0xFF+1 -> 0x00 reported as 0x00).

Reset
REQ-029 rst_n low: state ARB, cmd_out 0x00, ready both 0, rsp_valid 0, rsp_id 0, rsp_data 0x00, busy 0, last_grant = 1 (requester 0 wins first contention).
REQ-030 rst_n asserted mid-command SHALL abort immediately with outputs at REQ-029 values; first grant after release follows REQ-029 last_grant.
REQ-031 Release of rst_n SHALL take effect on the next rising clk edge; no grant in the release cycle unless valid already high.

Verification
REQ-032 Reset, req0 LOAD 0x5A -> req0_ready pulse, cmd_out 0x01 then 0x5A, RESP rsp_id 0, rsp_data = core acc 0x5A, busy 4 cycles total... (ARB grant cycle busy=0, then 3 busy).
REQ-033 Both valid continuously, prio_fixed=0, ops ADD -> grants alternate 0,1,0,1; rsp_id alternates; acc 0x00 -> 0x01,0x02,0x03,0x04.
REQ-034 Both valid, prio_fixed=1 -> four consecutive grants to req0, req1_ready never pulses.
REQ-035 LOAD 0xFF then ADD -> rsp_data 0xFF then 0x00; SUB from 0x00 -> 0xFF.
REQ-036 ena dropped in OPND -> next cycle cmd_out 0x00, state ARB, no rsp_valid; re-enabled with req1 valid -> req1 granted.
REQ-037 rst_n pulsed low during OPC with req1 previously granted -> all outputs per REQ-029; after release both valid -> req0 granted first.

Source files
------------

// File: rtl/acc_cmd_arbiter_if.sv
// Signal bundle between two command requesters, the accumulator core and the
// arbiter. master = requesters/core side, slave = arbiter side.
interface acc_cmd_arbiter_if;
  logic       ena;
  logic       prio_fixed;
  logic       req0_valid;
  logic [1:0] req0_op;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_op;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] cmd_out;
  logic [7:0] acc_in;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output ena, prio_fixed,
    output req0_valid, req0_op, req0_data,
    output req1_valid, req1_op, req1_data,
    output acc_in,
    input  req0_ready, req1_ready,
    input  cmd_out, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  ena, prio_fixed,
    input  req0_valid, req0_op, req0_data,
    input  req1_valid, req1_op, req1_data,
    input  acc_in,
    output req0_ready, req1_ready,
    output cmd_out, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/acc_cmd_arbiter.sv
// Two-requester command arbiter feeding an accumulator core: grant, send
// opcode byte, send operand byte, then report the accumulator value back.
module acc_cmd_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  acc_cmd_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OPC  = 2'd1,
    OPND = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'd0;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cmd_out_q, cmd_out_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  logic       grant_any;
  logic       grant_id;
  logic [1:0] sel_op;
  logic [7:0] sel_data;
  logic       rsp_fire;

  // Grant is combinational so the winner sees ready in the same cycle it
  // presents valid; rst_n gating keeps ready low while reset is held.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && bus_io.ena && (state_q == ARB) &&
        (bus_io.req0_valid || bus_io.req1_valid)) begin
      grant_any = 1'b1;
      if (bus_io.req0_valid && bus_io.req1_valid) begin
        grant_id = bus_io.prio_fixed ? 1'b0 : ~last_grant_q;
      end else begin
        grant_id = bus_io.req1_valid;
      end
    end
    sel_op   = grant_id ? bus_io.req1_op   : bus_io.req0_op;
    sel_data = grant_id ? bus_io.req1_data : bus_io.req0_data;
  end

  assign rsp_fire = (state_q == RESP) && bus_io.ena;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cmd_out_d    = 8'h00;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;

    if (!bus_io.ena) begin
      state_d = ARB;
    end else begin
      case (state_q)
        ARB: begin
          if (grant_any) begin
            state_d      = OPC;
            op_d         = sel_op;
            data_d       = sel_data;
            id_d         = grant_id;
            last_grant_d = grant_id;
            cmd_out_d    = {6'b000000, sel_op} + 8'd1;
          end
        end
        OPC: begin
          state_d   = OPND;
          cmd_out_d = (op_q == OP_LOAD) ? data_q : 8'h00;
        end
        OPND: begin
          state_d = RESP;
        end
        RESP: begin
          state_d    = ARB;
          rsp_id_d   = id_q;
          rsp_data_d = bus_io.acc_in;
        end
      endcase
    end
  end

  // cmd_out is precomputed one cycle ahead so the core bus is driven
  // straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      op_q         <= 2'd0;
      data_q       <= 8'h00;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_out_q    <= 8'h00;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cmd_out_q    <= cmd_out_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus_io.req0_ready = grant_any & ~grant_id;
  assign bus_io.req1_ready = grant_any &  grant_id;
  assign bus_io.cmd_out    = cmd_out_q;
  assign bus_io.rsp_valid  = rsp_fire;
  assign bus_io.rsp_id     = rsp_fire ? id_q          : rsp_id_q;
  assign bus_io.rsp_data   = rsp_fire ? bus_io.acc_in : rsp_data_q;
  assign bus_io.busy       = (state_q != ARB);

endmodule

// File: tb/tb_acc_cmd_arbiter.sv
// Bench for acc_cmd_arbiter: a byte-decoding accumulator core plus a
// transaction-level reference model that predicts every output each cycle.
module tb_acc_cmd_arbiter;

  localparam bit [1:0] LOAD  = 2'd0;
  localparam bit [1:0] ADD   = 2'd1;
  localparam bit [1:0] SUB   = 2'd2;
  localparam bit [1:0] STORE = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  acc_cmd_arbiter_if bus ();

  acc_cmd_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rdy0Cnt = 0;
  int rdy1Cnt = 0;

  bit       tEna, tPrio, tV0, tV1;
  bit [1:0] tOp0, tOp1;
  bit [7:0] tD0, tD1;

  // Reference model: phase counts cycles since the grant (0 = idle).
  int       mPhase = 0;
  bit       mLast = 1'b1;
  bit [1:0] mOp;
  bit [7:0] mData;
  bit       mId;
  bit [7:0] mAcc = 8'h00;
  bit       mRspId = 1'b0;
  bit [7:0] mRspData = 8'h00;
  bit       gAny, gId;

  // Accumulator core: latches an opcode byte while busy, consumes the
  // following byte as operand, and drops a half-received command if busy falls.
  logic [7:0] coreAcc = 8'h00;
  logic [7:0] coreOp = 8'h00;
  logic       coreHaveOp = 1'b0;

  assign bus.acc_in = coreAcc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coreHaveOp <= 1'b0;
    end else if (coreHaveOp) begin
      coreHaveOp <= 1'b0;
      if (bus.busy) begin
        case (coreOp)
          8'h01:   coreAcc <= bus.cmd_out;
          8'h02:   coreAcc <= coreAcc + 8'd1;
          8'h03:   coreAcc <= coreAcc - 8'd1;
          default: coreAcc <= coreAcc;
        endcase
      end
    end else if (bus.busy && bus.cmd_out >= 8'h01 && bus.cmd_out <= 8'h04) begin
      coreOp     <= bus.cmd_out;
      coreHaveOp <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ena, input bit prio,
                               input bit v0, input bit [1:0] op0, input bit [7:0] d0,
                               input bit v1, input bit [1:0] op1, input bit [7:0] d1);
    @(negedge clk);
    tEna = ena; tPrio = prio;
    tV0 = v0; tOp0 = op0; tD0 = d0;
    tV1 = v1; tOp1 = op1; tD1 = d1;
    bus.ena        = ena;
    bus.prio_fixed = prio;
    bus.req0_valid = v0;
    bus.req0_op    = op0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_op    = op1;
    bus.req1_data  = d1;
    rst_n          = rst;
  endtask

  function automatic void resetModel();
    mPhase   = 0;
    mLast    = 1'b1;
    mRspId   = 1'b0;
    mRspData = 8'h00;
  endfunction

  function automatic void modelExecute();
    case (mOp)
      LOAD:    mAcc = mData;
      ADD:     mAcc = mAcc + 8'd1;
      SUB:     mAcc = mAcc - 8'd1;
      default: mAcc = mAcc;
    endcase
  endfunction

  // Predict and compare all outputs for the current cycle, then advance the
  // model across the next rising edge.
  task automatic checkCycle();
    logic [7:0] expCmd;
    bit         expFire;
    if (!rst_n) resetModel();
    #1;
    gAny = 1'b0;
    gId  = 1'b0;
    if (rst_n && mPhase == 0 && tEna && (tV0 || tV1)) begin
      gAny = 1'b1;
      gId  = (tV0 && tV1) ? (tPrio ? 1'b0 : !mLast) : tV1;
    end
    expCmd = 8'h00;
    if (mPhase == 1) expCmd = 8'(mOp) + 8'd1;
    else if (mPhase == 2 && mOp == LOAD) expCmd = mData;
    expFire = (mPhase == 3) && tEna;

    checkOutput("req0_ready", 8'(bus.req0_ready), 8'(gAny && !gId));
    checkOutput("req1_ready", 8'(bus.req1_ready), 8'(gAny && gId));
    checkOutput("cmd_out",    bus.cmd_out,        expCmd);
    checkOutput("busy",       8'(bus.busy),       8'(mPhase != 0));
    checkOutput("rsp_valid",  8'(bus.rsp_valid),  8'(expFire));
    checkOutput("rsp_id",     8'(bus.rsp_id),     8'(expFire ? mId : mRspId));
    checkOutput("rsp_data",   bus.rsp_data,       expFire ? mAcc : mRspData);
    rdy0Cnt += int'(bus.req0_ready);
    rdy1Cnt += int'(bus.req1_ready);

    @(posedge clk);
    if (rst_n) begin
      if (!tEna) begin
        if (mPhase == 2) modelExecute();
        mPhase = 0;
      end else begin
        case (mPhase)
          0: if (gAny) begin
               mId    = gId;
               mLast  = gId;
               mOp    = gId ? tOp1 : tOp0;
               mData  = gId ? tD1  : tD0;
               mPhase = 1;
             end
          1: mPhase = 2;
          2: begin modelExecute(); mPhase = 3; end
          default: begin mRspId = mId; mRspData = mAcc; mPhase = 0; end
        endcase
      end
    end
  endtask

  task automatic runCmd(input bit id, input bit [1:0] op, input bit [7:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, !id, op, data, id, op, data);
    checkCycle();
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, LOAD, 8'h00, 1'b0, LOAD, 8'h00);
      checkCycle();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, LOAD, 8'h00, 1'b0, LOAD, 8'h00);
      checkCycle();
    end
  endtask

  initial begin
    int       base0, base1;
    bit       pend0, pend1, rEna, rPrio;
    bit [1:0] rOp0, rOp1;
    bit [7:0] rD0, rD1;

    // Reset held with both requesters pending: nothing may be granted.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, LOAD, 8'h5A, 1'b1, ADD, 8'h00);
    #1;
    checkOutput("rst_cmd_out",   bus.cmd_out,           8'h00);
    checkOutput("rst_ready0",    8'(bus.req0_ready),    8'h00);
    checkOutput("rst_ready1",    8'(bus.req1_ready),    8'h00);
    checkOutput("rst_rsp_valid", 8'(bus.rsp_valid),     8'h00);
    checkOutput("rst_rsp_id",    8'(bus.rsp_id),        8'h00);
    checkOutput("rst_rsp_data",  bus.rsp_data,          8'h00);
    checkOutput("rst_busy",      8'(bus.busy),          8'h00);
    checkCycle();
    idle(2);

    // Single LOAD from requester 0
    runCmd(1'b0, LOAD, 8'h5A);
    checkOutput("load_rsp_data", bus.rsp_data,   8'h5A);
    checkOutput("load_rsp_id",   8'(bus.rsp_id), 8'h00);

    // Round-robin contention with ADDs from a zeroed accumulator
    runCmd(1'b1, LOAD, 8'h00);
    base0 = rdy0Cnt; base1 = rdy1Cnt;
    repeat (16) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, ADD, 8'h00, 1'b1, ADD, 8'h00);
      checkCycle();
    end
    checkOutput("rr_grants0",   8'(rdy0Cnt - base0), 8'd2);
    checkOutput("rr_grants1",   8'(rdy1Cnt - base1), 8'd2);
    checkOutput("rr_rsp_data",  bus.rsp_data,        8'h04);
    checkOutput("rr_rsp_id",    8'(bus.rsp_id),      8'h01);

    // Fixed priority contention
    base0 = rdy0Cnt; base1 = rdy1Cnt;
    repeat (16) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, STORE, 8'h00, 1'b1, STORE, 8'h00);
      checkCycle();
    end
    checkOutput("fixed_grants0", 8'(rdy0Cnt - base0), 8'd4);
    checkOutput("fixed_grants1", 8'(rdy1Cnt - base1), 8'd0);

    // No wrap handling: values pass straight through from the core
    runCmd(1'b0, LOAD, 8'hFF);
    checkOutput("wrap_load", bus.rsp_data, 8'hFF);
    runCmd(1'b1, ADD, 8'h00);
    checkOutput("wrap_add",  bus.rsp_data, 8'h00);
    runCmd(1'b0, SUB, 8'h00);
    checkOutput("wrap_sub",  bus.rsp_data, 8'hFF);

    // Enable dropped during the operand cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, ADD, 8'h00, 1'b0, LOAD, 8'h00);
    checkCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, ADD, 8'h00, 1'b0, LOAD, 8'h00);
    checkCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, ADD, 8'h00, 1'b0, LOAD, 8'h00);
    checkCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, LOAD, 8'h00, 1'b1, LOAD, 8'h33);
    #1;
    checkOutput("ena_cmd_out",   bus.cmd_out,        8'h00);
    checkOutput("ena_busy",      8'(bus.busy),       8'h00);
    checkOutput("ena_rsp_valid", 8'(bus.rsp_valid),  8'h00);
    checkOutput("ena_ready1",    8'(bus.req1_ready), 8'h01);
    checkCycle();
    idle(3);
    checkOutput("ena_rsp_data",  bus.rsp_data, 8'h33);

    // Reset in the middle of a requester-1 command
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, LOAD, 8'h00, 1'b1, LOAD, 8'h11);
    checkCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, LOAD, 8'h22, 1'b1, LOAD, 8'h44);
    #1;
    checkOutput("abort_cmd_out",   bus.cmd_out,        8'h00);
    checkOutput("abort_busy",      8'(bus.busy),       8'h00);
    checkOutput("abort_ready0",    8'(bus.req0_ready), 8'h00);
    checkOutput("abort_ready1",    8'(bus.req1_ready), 8'h00);
    checkOutput("abort_rsp_id",    8'(bus.rsp_id),     8'h00);
    checkOutput("abort_rsp_data",  bus.rsp_data,       8'h00);
    checkCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, LOAD, 8'h22, 1'b1, LOAD, 8'h44);
    #1;
    checkOutput("abort_first_ready0", 8'(bus.req0_ready), 8'h01);
    checkOutput("abort_first_ready1", 8'(bus.req1_ready), 8'h00);
    checkCycle();
    idle(3);
    checkOutput("abort_rsp_data2", bus.rsp_data,   8'h22);
    checkOutput("abort_rsp_id2",   8'(bus.rsp_id), 8'h00);

    // Randomized traffic; requesters hold their command until accepted
    pend0 = 1'b0; pend1 = 1'b0;
    rPrio = 1'b0; rOp0 = LOAD; rOp1 = LOAD; rD0 = 8'h00; rD1 = 8'h00;
    for (int c = 0; c < 800; c++) begin
      if (c % 64 == 0) rPrio = 1'($urandom_range(0, 1));
      rEna = ($urandom_range(0, 15) != 0);
      if (!pend0) begin
        pend0 = ($urandom_range(0, 2) != 0);
        rOp0  = 2'($urandom_range(0, 3));
        rD0   = 8'($urandom);
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 2) != 0);
        rOp1  = 2'($urandom_range(0, 3));
        rD1   = 8'($urandom);
      end
      applyStimulus(1'b1, rEna, rPrio, pend0, rOp0, rD0, pend1, rOp1, rD1);
      checkCycle();
      if (gAny) begin
        if (gId) pend1 = 1'b0;
        else     pend0 = 1'b0;
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
